demux_1to3_reg: RTL and testbench
=================================

// Module: demux_1to3_reg
// PURPOSE
//  Registered 1-to-3 stream demultiplexer; the steering counterpart of the 3-to-1 select mux.
//  Accepts one word per cycle on a valid/ready input and routes it to channel A, B or C by a 2-bit select.
//  Holds the routed word in a one-entry output register and supports back-to-back throughput.
//  Sits between a single producer, such as a result or write-back bus, and three independent consumers.
// PARAMETERS
//  DATAWIDTH  32  width of data word (in_data, out_data)
//  CNTWIDTH   8   width of saturating drop counter
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          producer has a word
//  in_ready   out  1          block accepts word this cycle
//  in_data    in   DATAWIDTH  word to route
//  in_sel     in   2          destination: 00=A 01=B 10=C 11=illegal
//  out_data   out  DATAWIDTH  registered word (shared by all channels)
//  outA_valid out  1          out_data valid for channel A
//  outB_valid out  1          out_data valid for channel B
//  outC_valid out  1          out_data valid for channel C
//  outA_ready in   1          channel A consumes
//  outB_ready in   1          channel B consumes
//  outC_ready in   1          channel C consumes
//  drop_pulse out  1          1-cycle pulse: illegal-select word discarded
//  drop_cnt   out  CNTWIDTH   saturating count of discarded words
// BEHAVIOUR
//  Reset (async, rst_n=0): full=0, dest=00, out_data=0, all outX_valid=0, drop_pulse=0, drop_cnt=0.
//  Storage: one register {full, dest[1:0], data}.
//  outX_valid = full & (dest==X). At most one outX_valid is high at any time.
//  sel_ready = ready of the channel named by dest (A/B/C).
//  in_ready = !full | sel_ready (combinational). The path from out ready to in_ready is allowed.
//  accept = in_valid & in_ready. drain = full & sel_ready.
//  States: EMPTY (full=0) and HOLD (full=1).
//   EMPTY, accept with sel!=11 -> HOLD; load data and dest.
//   EMPTY, accept with sel==11 -> stay EMPTY; drop the word.
//   HOLD, drain and no legal accept -> EMPTY.
//   HOLD, drain and a legal accept in the same cycle -> HOLD; reload with the new word (back-to-back).
//   HOLD, drain and an illegal accept in the same cycle -> EMPTY; drop the word.
//   HOLD, no drain -> hold; in_ready=0, and data and dest are stable.
//  Latency: accept at edge N gives outX_valid high after edge N. Throughput is 1 word/cycle when the consumer is ready.
//  Word held in HOLD: out_data and dest do not change until drain (AXI-style stability). in_data and in_sel may change while in_ready=0.
//  Illegal sel (11): the word is accepted when in_ready=1 and never appears on any output.
//   drop_pulse=1 for exactly the cycle after the accept.
//   drop_cnt increments by 1 and saturates at 2^CNTWIDTH-1 (no wrap).
//  Readies of non-selected channels are ignored. Those channels' valid stays 0.
//  in_valid=0: no state change except drain.
//  rst_n asserted mid-transfer: the held word is lost, and outputs return to reset values immediately (async).
//  Deassertion of reset is synchronised externally. The first accept is possible on the first edge after rst_n=1.
// TESTING
//  T1 reset: drive rst_n=0 mid-HOLD with outB_valid=1 -> outB_valid=0 at once, in_ready=1, drop_cnt=0.
//  T2 single route: in_data=32'hDEADBEEF, sel=01, all ready=1 -> next cycle outB_valid=1, out_data=DEADBEEF, A and C valid=0.
//  T3 backpressure: sel=10, outC_ready=0 for 5 cycles -> outC_valid=1 and data stable, in_ready=0; outC_ready=1 -> drains in 1 cycle.
//  T4 streaming: 8 words with sel pattern 00,01,10,00,..., all ready=1 -> one word per cycle, each on the correct channel, in order, no gaps.
//  T5 illegal: sel=11 with data 32'h1234 -> drop_pulse for 1 cycle, drop_cnt=1, no outX_valid. Send 300 illegal words (CNTWIDTH=8) -> drop_cnt=255.
//  T6 simultaneous: HOLD on A, outA_ready=1 with new sel=10 word in the same cycle -> next cycle outC_valid=1 with the new data and outA_valid=0.

Source files
------------

// File: rtl/demux_1to3_reg.sv
// Registered 1-to-3 stream demultiplexer.
// Takes one word per cycle on a valid/ready input and steers it to channel
// A, B or C according to in_sel, holding it in a one-entry output register.
// When in_sel is 11 the word is accepted and then discarded. A saturating
// counter tracks how many words have been discarded this way.
//
//  state | meaning
//  ------+-------------------------------------------------
//  EMPTY | output register free, in_ready=1
//  HOLD  | word held for channel 'dest', stable until drained
module demux_1to3_reg #(
  parameter int DATAWIDTH = 32,
  parameter int CNTWIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic [1:0]           in_sel,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 outA_valid,
  output logic                 outB_valid,
  output logic                 outC_valid,
  input  logic                 outA_ready,
  input  logic                 outB_ready,
  input  logic                 outC_ready,
  output logic                 drop_pulse,
  output logic [CNTWIDTH-1:0]  drop_cnt
);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [1:0] DEST_A = 2'b00;
  localparam logic [1:0] DEST_B = 2'b01;
  localparam logic [1:0] DEST_C = 2'b10;
  localparam logic [1:0] DEST_X = 2'b11;

  state_t                 state;
  state_t                 state_next;
  logic [1:0]             dest;
  logic                   sel_ready;
  logic                   accept;
  logic                   legal_acc;
  logic                   illegal_acc;
  logic                   drain;

  // Ready of the consumer currently addressed by the held word.
  always_comb begin
    sel_ready = 1'b0;
    case (dest)
      DEST_A:  sel_ready = outA_ready;
      DEST_B:  sel_ready = outB_ready;
      DEST_C:  sel_ready = outC_ready;
      default: sel_ready = 1'b0;
    endcase
  end

  assign accept      = in_valid & in_ready;
  assign legal_acc   = accept & (in_sel != DEST_X);
  assign illegal_acc = accept & (in_sel == DEST_X);
  assign drain       = (state == HOLD) & sel_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Next state: a legal accept always leaves a word held; otherwise a drain empties.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (legal_acc) state_next = HOLD;
      HOLD: begin
        if (legal_acc)  state_next = HOLD;
        else if (drain) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  // Outputs: in_ready passes the addressed consumer's ready straight through
  // so a held word can be replaced in the same cycle it drains.
  always_comb begin
    in_ready   = (state == EMPTY) | sel_ready;
    outA_valid = (state == HOLD) & (dest == DEST_A);
    outB_valid = (state == HOLD) & (dest == DEST_B);
    outC_valid = (state == HOLD) & (dest == DEST_C);
  end

  // Payload and destination load only on a legal accept, so they stay stable while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      dest     <= DEST_A;
    end else if (legal_acc) begin
      out_data <= in_data;
      dest     <= in_sel;
    end
  end

  // Discard reporting: one-cycle pulse and a counter that sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= illegal_acc;
      if (illegal_acc && (drop_cnt != {CNTWIDTH{1'b1}}))
        drop_cnt <= drop_cnt + CNTWIDTH'(1);
    end
  end

endmodule

// File: tb/tb_demux_1to3_reg.sv
// Bench for demux_1to3_reg: directed scenarios followed by random traffic,
// all compared against a one-entry queue model of the stream.
module tb_demux_1to3_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic [31:0] out_data;
  logic        outA_valid, outB_valid, outC_valid;
  logic        outA_ready, outB_ready, outC_ready;
  logic        drop_pulse;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  dest;
    logic [31:0] data;
  } item_t;

  item_t m_q[$];
  int    m_cnt   = 0;
  bit    m_pulse = 0;

  always #5 clk = ~clk;

  demux_1to3_reg #(.DATAWIDTH(32), .CNTWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_data(out_data),
    .outA_valid(outA_valid), .outB_valid(outB_valid), .outC_valid(outC_valid),
    .outA_ready(outA_ready), .outB_ready(outB_ready), .outC_ready(outC_ready),
    .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare against the model, then
  // advance the model to what the coming posedge should produce.
  task automatic step(input logic v, input logic [31:0] d, input logic [1:0] s,
                      input logic ra, input logic rb, input logic rc);
    bit   r[3];
    bit   has, drained, exp_ready, acc;
    logic [4:0] exp_flags;
    @(negedge clk);
    in_valid = v; in_data = d; in_sel = s;
    outA_ready = ra; outB_ready = rb; outC_ready = rc;
    #1;
    r[0] = ra; r[1] = rb; r[2] = rc;
    has       = (m_q.size() != 0);
    drained   = has && r[m_q[0].dest];
    exp_ready = !has || drained;
    exp_flags = {has && m_q[0].dest == 2'd0, has && m_q[0].dest == 2'd1,
                 has && m_q[0].dest == 2'd2, exp_ready, m_pulse};
    check_val("flags", {outA_valid, outB_valid, outC_valid, in_ready, drop_pulse}, exp_flags);
    if (has) check_val("out_data", out_data, m_q[0].data);
    check_val("drop_cnt", drop_cnt, m_cnt);
    acc = v && exp_ready;
    if (drained) void'(m_q.pop_front());
    m_pulse = acc && (s == 2'd3);
    if (acc && s == 2'd3) begin
      if (m_cnt < 255) m_cnt++;
    end else if (acc) begin
      m_q.push_back('{dest: s, data: d});
    end
    if (m_q.size() > 1) check_val("model_depth", m_q.size(), 1);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt   = 0;
    m_pulse = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_data = '0; in_sel = '0;
    outA_ready = 0; outB_ready = 0; outC_ready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_flags", {outA_valid, outB_valid, outC_valid, in_ready, drop_pulse}, 5'b00010);
    check_val("rst_data", out_data, 0);
    check_val("rst_cnt", drop_cnt, 0);
    rst_n = 1'b1;

    // T2 single route to B
    step(1, 32'hDEADBEEF, 2'b01, 1, 1, 1);
    step(0, 32'h0, 2'b00, 1, 1, 1);
    check_val("t2_validB", {outA_valid, outB_valid, outC_valid}, 3'b010);
    check_val("t2_data", out_data, 32'hDEADBEEF);
    step(0, 32'h0, 2'b00, 1, 1, 1);

    // T3 backpressure on C; other readies high must be ignored
    step(1, 32'hC0C0_0003, 2'b10, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h5A5A_0000 + i, 2'(i), 1, 1, 0);
    check_val("t3_stall", {outC_valid, in_ready}, 2'b10);
    check_val("t3_data", out_data, 32'hC0C0_0003);
    step(0, 32'h0, 2'b00, 0, 0, 1);
    step(0, 32'h0, 2'b00, 0, 0, 1);
    check_val("t3_empty", {outA_valid, outB_valid, outC_valid, in_ready}, 4'b0001);

    // T4 streaming 8 words, one per cycle
    for (int i = 0; i < 8; i++) step(1, 32'h4000_0000 + i, 2'(i % 3), 1, 1, 1);
    step(0, 32'h0, 2'b00, 1, 1, 1);
    check_val("t4_last", {outA_valid, outB_valid, outC_valid}, 3'b010);
    check_val("t4_last_data", out_data, 32'h4000_0007);
    step(0, 32'h0, 2'b00, 1, 1, 1);

    // T6 drain A and load C in the same cycle
    step(1, 32'hAAAA_0001, 2'b00, 0, 0, 0);
    step(0, 32'h0, 2'b00, 0, 0, 0);
    step(1, 32'hCCCC_0002, 2'b10, 1, 0, 0);
    step(0, 32'h0, 2'b00, 0, 0, 0);
    check_val("t6_validC", {outA_valid, outB_valid, outC_valid}, 3'b001);
    check_val("t6_data", out_data, 32'hCCCC_0002);
    step(0, 32'h0, 2'b00, 0, 0, 1);

    // T1 async reset while holding a word for B
    step(1, 32'hB0B0_B0B0, 2'b01, 1, 0, 1);
    @(posedge clk); #1;
    check_val("t1_pre", outB_valid, 1);
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check_val("t1_flags", {outA_valid, outB_valid, outC_valid, in_ready, drop_pulse}, 5'b00010);
    check_val("t1_cnt", drop_cnt, 0);
    check_val("t1_data", out_data, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // T5 illegal select: drop, then saturation
    step(1, 32'h1234, 2'b11, 1, 1, 1);
    step(0, 32'h0, 2'b00, 1, 1, 1);
    check_val("t5_pulse", {drop_pulse, outA_valid, outB_valid, outC_valid}, 4'b1000);
    check_val("t5_cnt1", drop_cnt, 1);
    for (int i = 0; i < 300; i++) step(1, $urandom, 2'b11, 1, 1, 1);
    step(0, 32'h0, 2'b00, 1, 1, 1);
    check_val("t5_sat", drop_cnt, 255);

    // Random traffic from a fresh reset
    rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
